// File: rtl/dmem_pkg.sv
// Shared types and defaults for the data-memory responder: FSM states, size/latency defaults,
// counter width, and the address legality rule used by the responder.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int DEFAULT_DEPTH_WORDS = 256;
  localparam int DEFAULT_LATENCY     = 3;
  localparam int CNT_W               = 4;

  // Legal means word aligned and inside the storage window of 2**aw words.
  function automatic logic addr_legal(input logic [31:0] addr, input int aw);
    return (addr[1:0] == 2'b00) && ((addr >> (aw + 2)) == 32'd0);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word storage, 32 bits x DEPTH_WORDS: write at the clock edge when we=1, read is combinational.
// Latency: 0 cycles for reads, 1 edge for writes; no backpressure. Contents are never reset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk_i,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk_i) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// CPU data-memory responder: one access in flight, completion pulse LATENCY cycles after accept.
// Backpressure: req_ready_o only in IDLE; stall_o holds the pipeline until the response cycle.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
  parameter int LATENCY     = DEFAULT_LATENCY
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  input  logic        req_write_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        req_ready_o,
  output logic        resp_valid_o,
  output logic [31:0] resp_rdata_o,
  output logic        resp_err_o,
  output logic        stall_o
);

  localparam int               AW       = $clog2(DEPTH_WORDS);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 2);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             write_q;
  logic [31:0]      addr_q;
  logic [31:0]      wdata_q;

  logic             accept;
  logic             addr_ok;
  logic             mem_we;
  logic [AW-1:0]    word_idx;
  logic [31:0]      mem_rdata;

  assign accept   = req_valid_i && (state_q == IDLE);
  assign addr_ok  = addr_legal(addr_q, AW);
  assign word_idx = addr_q[AW+1:2];
  // A reset landing on the response edge must also cancel the store.
  assign mem_we   = (state_q == RESP) && rst_i && write_q && addr_ok;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      write_q <= req_write_i;
      addr_q  <= req_addr_i;
      wdata_q <= req_wdata_i;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    req_ready_o  = 1'b0;
    resp_valid_o = 1'b0;
    resp_err_o   = 1'b0;
    resp_rdata_o = '0;
    unique case (state_q)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          state_d = (LATENCY == 1) ? RESP : BUSY;
          cnt_d   = CNT_LOAD;
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      RESP: begin
        state_d = IDLE;
        // Outputs are gated by rst_i so an abort in this cycle shows no response.
        resp_valid_o = rst_i;
        resp_err_o   = rst_i && !addr_ok;
        resp_rdata_o = (rst_i && addr_ok && !write_q) ? mem_rdata : '0;
      end
      default: state_d = IDLE;
    endcase
    stall_o = req_valid_i && !resp_valid_o;
  end

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_array (
    .clk_i(clk_i),
    .we   (mem_we),
    .addr (word_idx),
    .wdata(wdata_q),
    .rdata(mem_rdata)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a LATENCY=3 and a LATENCY=1 instance, directed vectors,
// randomized traffic against a word-array model, and a reset-in-response sequence.
module tb_dmem_responder;

  localparam int DEPTH = 256;
  localparam int LAT_A = 3;
  localparam int LAT_B = 1;

  logic             clk = 1'b0;
  logic [1:0]       rst;
  logic [1:0]       req_valid;
  logic [1:0]       req_write;
  logic [1:0][31:0] req_addr;
  logic [1:0][31:0] req_wdata;
  logic [1:0]       ready;
  logic [1:0]       resp_valid;
  logic [1:0][31:0] rdata;
  logic [1:0]       err;
  logic [1:0]       stall;

  int checks   = 0;
  int failures = 0;

  logic [31:0] mdl_mem   [2][DEPTH];
  bit          mdl_known [2][DEPTH];

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT_A)) dut_a (
    .clk_i(clk), .rst_i(rst[0]), .req_valid_i(req_valid[0]), .req_write_i(req_write[0]),
    .req_addr_i(req_addr[0]), .req_wdata_i(req_wdata[0]), .req_ready_o(ready[0]),
    .resp_valid_o(resp_valid[0]), .resp_rdata_o(rdata[0]), .resp_err_o(err[0]),
    .stall_o(stall[0])
  );

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT_B)) dut_b (
    .clk_i(clk), .rst_i(rst[1]), .req_valid_i(req_valid[1]), .req_write_i(req_write[1]),
    .req_addr_i(req_addr[1]), .req_wdata_i(req_wdata[1]), .req_ready_o(ready[1]),
    .resp_valid_o(resp_valid[1]), .resp_rdata_o(rdata[1]), .resp_err_o(err[1]),
    .stall_o(stall[1])
  );

  function automatic int lat_of(input int s);
    return (s == 0) ? LAT_A : LAT_B;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", nm, act, exp);
    end
  endtask

  task automatic chk_bit(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b expected=%b", nm, act, exp);
    end
  endtask

  // Reference: a plain word array; legal = aligned and below 4*DEPTH bytes.
  task automatic model_step(input int s, input logic w, input logic [31:0] a, input logic [31:0] d,
                            output logic e, output logic kr, output logic [31:0] rd);
    int unsigned idx;
    e  = ((a % 4) != 0) || (a >= 32'(4 * DEPTH));
    kr = 1'b1;
    rd = 32'd0;
    if (!e) begin
      idx = a / 4;
      if (w) begin
        mdl_mem[s][idx]   = d;
        mdl_known[s][idx] = 1'b1;
      end else begin
        kr = mdl_known[s][idx];
        rd = mdl_mem[s][idx];
      end
    end
  endtask

  // Called at a negedge. Drives a request, waits for acceptance, then checks every cycle up to the response.
  task automatic txn(input int s, input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic exp_err, input logic kr, input logic [31:0] exp_rd,
                     input bit scr, input int exp_wait, input string nm);
    int t;
    int lat;
    lat = lat_of(s);
    req_valid[1-s] = 1'b0;
    req_valid[s] = 1'b1;
    req_write[s] = w;
    req_addr[s]  = a;
    req_wdata[s] = d;
    #1;
    t = 0;
    while (ready[s] !== 1'b1 && t < 40) begin
      @(negedge clk);
      #1;
      t++;
    end
    chk({nm, "_accept_wait"}, 32'(t), 32'(exp_wait));
    if (ready[s] !== 1'b1) begin
      req_valid[s] = 1'b0;
      return;
    end
    chk_bit({nm, "_stall_accept"}, stall[s], 1'b1);
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      #1;
      if (k < lat) begin
        chk_bit({nm, "_early_valid"}, resp_valid[s], 1'b0);
        chk_bit({nm, "_busy_ready"}, ready[s], 1'b0);
        chk_bit({nm, "_busy_stall"}, stall[s], 1'b1);
      end else begin
        chk_bit({nm, "_resp_valid"}, resp_valid[s], 1'b1);
        chk_bit({nm, "_resp_ready"}, ready[s], 1'b0);
        chk_bit({nm, "_resp_stall"}, stall[s], 1'b0);
        chk_bit({nm, "_resp_err"}, err[s], exp_err);
        if (kr) chk({nm, "_resp_rdata"}, rdata[s], exp_rd);
      end
      if (scr && k == 1) begin
        req_addr[s]  = $urandom;
        req_wdata[s] = $urandom;
        req_write[s] = ~w;
      end
    end
  endtask

  typedef struct {
    int          s;
    logic        w;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rd;
    bit          b2b;
  } vec_t;

  vec_t vecs [16];

  initial begin
    logic        e;
    logic        kr;
    logic [31:0] rd;
    logic [31:0] a;
    logic [31:0] d;
    logic        w;
    int          s;
    int          last_s;
    int          r;

    vecs[0]  = '{0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0,         1'b0};
    vecs[1]  = '{0, 1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF, 1'b1};
    vecs[2]  = '{0, 1'b1, 32'h0000_0000, 32'hA5A5_0001, 1'b0, 32'h0,         1'b0};
    vecs[3]  = '{0, 1'b0, 32'h0000_0000, 32'h0,         1'b0, 32'hA5A5_0001, 1'b1};
    vecs[4]  = '{0, 1'b0, 32'h0000_0012, 32'h0,         1'b1, 32'h0,         1'b1};
    vecs[5]  = '{0, 1'b1, 32'h0000_0400, 32'hFFFF_FFFF, 1'b1, 32'h0,         1'b0};
    vecs[6]  = '{0, 1'b0, 32'h0000_0000, 32'h0,         1'b0, 32'hA5A5_0001, 1'b1};
    vecs[7]  = '{0, 1'b1, 32'h0000_03FC, 32'h0BAD_F00D, 1'b0, 32'h0,         1'b0};
    vecs[8]  = '{0, 1'b0, 32'h0000_03FC, 32'h0,         1'b0, 32'h0BAD_F00D, 1'b1};
    vecs[9]  = '{0, 1'b0, 32'h8000_0000, 32'h0,         1'b1, 32'h0,         1'b1};
    vecs[10] = '{0, 1'b1, 32'h0000_03FD, 32'h1111_2222, 1'b1, 32'h0,         1'b1};
    vecs[11] = '{1, 1'b1, 32'h0000_0004, 32'h1234_5678, 1'b0, 32'h0,         1'b0};
    vecs[12] = '{1, 1'b0, 32'h0000_0004, 32'h0,         1'b0, 32'h1234_5678, 1'b1};
    vecs[13] = '{1, 1'b0, 32'h0000_0006, 32'h0,         1'b1, 32'h0,         1'b1};
    vecs[14] = '{1, 1'b1, 32'h0000_0000, 32'hCAFE_0000, 1'b0, 32'h0,         1'b1};
    vecs[15] = '{1, 1'b0, 32'h0000_0000, 32'h0,         1'b0, 32'hCAFE_0000, 1'b1};

    rst       = 2'b00;
    req_valid = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    repeat (3) @(negedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk_bit($sformatf("reset%0d_ready", i), ready[i], 1'b1);
      chk_bit($sformatf("reset%0d_valid", i), resp_valid[i], 1'b0);
      chk_bit($sformatf("reset%0d_err", i), err[i], 1'b0);
      chk($sformatf("reset%0d_rdata", i), rdata[i], 32'h0);
      chk_bit($sformatf("reset%0d_stall_idle", i), stall[i], 1'b0);
    end
    req_valid[0] = 1'b1;
    #1;
    chk_bit("reset_stall_follows_valid", stall[0], 1'b1);
    req_valid[0] = 1'b0;
    rst = 2'b11;
    @(negedge clk);

    for (int i = 0; i < 16; i++) begin
      if (!vecs[i].b2b) begin
        req_valid[vecs[i].s] = 1'b0;
        @(negedge clk);
      end
      model_step(vecs[i].s, vecs[i].w, vecs[i].addr, vecs[i].wdata, e, kr, rd);
      txn(vecs[i].s, vecs[i].w, vecs[i].addr, vecs[i].wdata, vecs[i].exp_err, 1'b1,
          vecs[i].exp_rd, 1'b0, vecs[i].b2b ? 1 : 0, $sformatf("vec%0d", i));
    end

    last_s = 1;
    for (int n = 0; n < 300; n++) begin
      s = $urandom_range(0, 1);
      w = 1'($urandom_range(0, 1));
      r = $urandom_range(0, 9);
      if (r < 8) a = 32'($urandom_range(0, 15)) << 2;
      else if (r == 8) a = (32'($urandom_range(0, 255)) << 2) | 32'($urandom_range(1, 3));
      else a = 32'h400 | ($urandom & 32'hFFFF_FFFC);
      d = $urandom;
      model_step(s, w, a, d, e, kr, rd);
      if (s != last_s || $urandom_range(0, 3) == 0) begin
        req_valid[0] = 1'b0;
        req_valid[1] = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
        txn(s, w, a, d, e, kr, rd, 1'($urandom_range(0, 1)), 0, $sformatf("rnd%0d", n));
      end else begin
        txn(s, w, a, d, e, kr, rd, 1'($urandom_range(0, 1)), 1, $sformatf("rnd%0d", n));
      end
      last_s = s;
    end

    // Reset in the response cycle of a store must cancel both the pulse and the write.
    req_valid = '0;
    @(negedge clk);
    model_step(0, 1'b1, 32'h8, 32'h1111_1111, e, kr, rd);
    txn(0, 1'b1, 32'h8, 32'h1111_1111, 1'b0, 1'b1, 32'h0, 1'b0, 0, "rst_prestore");
    req_valid[0] = 1'b0;
    @(negedge clk);
    req_valid[0] = 1'b1;
    req_write[0] = 1'b1;
    req_addr[0]  = 32'h8;
    req_wdata[0] = 32'h55;
    #1;
    chk_bit("rst_accept_ready", ready[0], 1'b1);
    for (int k = 1; k <= LAT_A; k++) begin
      @(negedge clk);
      #1;
      if (k < LAT_A) chk_bit("rst_busy_valid", resp_valid[0], 1'b0);
    end
    chk_bit("rst_reached_resp", resp_valid[0], 1'b1);
    rst[0] = 1'b0;
    req_valid[0] = 1'b0;
    #1;
    chk_bit("rst_resp_suppressed", resp_valid[0], 1'b0);
    chk_bit("rst_resp_err", err[0], 1'b0);
    @(negedge clk);
    rst[0] = 1'b1;
    #1;
    chk_bit("rst_ready_after", ready[0], 1'b1);
    chk_bit("rst_no_late_valid", resp_valid[0], 1'b0);
    txn(0, 1'b0, 32'h8, 32'h0, 1'b0, 1'b1, 32'h1111_1111, 1'b0, 0, "rst_reload");
    req_valid = '0;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameters: DEPTH_WORDS, default 256, storage size in 32-bit words (power of 2).
REQ-002 Parameters: LATENCY, default 3, cycles from accept to response (legal range 1..15).
REQ-003 The block SHALL use one clock; reset is synchronous and active-low.
REQ-004 Port clk_i, input, 1 bit: the single clock, rising-edge.
REQ-005 Port rst_i, input, 1 bit: synchronous active-low reset.
REQ-006 Port req_valid_i, input, 1 bit: CPU MEM-stage access request.
REQ-007 Port req_write_i, input, 1 bit: 1 = store, 0 = load.
REQ-008 Port req_addr_i, input, 32 bits: byte address (ALU result).
REQ-009 Port req_wdata_i, input, 32 bits: store data.
REQ-010 Port req_ready_o, output, 1 bit: the responder can accept a request this cycle.
REQ-011 Port resp_valid_o, output, 1 bit: one-cycle completion pulse (loads and stores).
REQ-012 Port resp_rdata_o, output, 32 bits: load data, valid while resp_valid_o=1.
REQ-013 Port resp_err_o, output, 1 bit: the completed access was illegal, valid while resp_valid_o=1.
REQ-014 Port stall_o, output, 1 bit: pipeline freeze request to the hazard logic.

Function
REQ-015 The FSM SHALL have three states: IDLE, BUSY and RESP.
REQ-016 req_ready_o SHALL be 1 only in IDLE.
REQ-017 Accept occurs when req_valid_i=1 and req_ready_o=1. On accept, the block SHALL capture write, addr and wdata into holding registers.
REQ-018 On accept, the next state SHALL be RESP when LATENCY=1, and BUSY otherwise. The down-counter SHALL load LATENCY-2.
REQ-019 In BUSY, the counter SHALL decrement each cycle. At 0, the next state SHALL be RESP.
REQ-020 In RESP, resp_valid_o SHALL be 1 for exactly one cycle, and the next state SHALL be IDLE.
REQ-021 resp_valid_o SHALL rise exactly LATENCY cycles after the accept edge.
REQ-022 Requests SHALL NOT be accepted in BUSY or RESP. The maximum throughput is one access per LATENCY+1 cycles.
REQ-023 Word index = addr[clog2(DEPTH_WORDS)+1:2].
REQ-024 An access is illegal if addr[1:0]!=0 or addr[31:clog2(DEPTH_WORDS)+2]!=0.
REQ-025 For a legal store, the storage word SHALL be written at the RESP-cycle clock edge. resp_rdata_o SHALL be 0.
REQ-026 For a legal load, resp_rdata_o SHALL be the storage word read combinationally in RESP.
REQ-027 For an illegal access, there SHALL be no storage write, resp_err_o=1, resp_rdata_o=0, and the same latency.
REQ-028 Outside RESP, resp_rdata_o=0 and resp_err_o=0.
REQ-029 stall_o = req_valid_i AND NOT resp_valid_o (combinational). This freezes the CPU from its request cycle up to, but not including, the response cycle.
REQ-030 The requester holds req_* stable until resp_valid_o. Input changes after accept SHALL have no effect on the transaction in flight.
REQ-031 A request present in the RESP cycle SHALL NOT be accepted. It is accepted in the following IDLE cycle if still asserted.
REQ-032 Counter width SHALL be 4 bits. There is no wrap-around path, because the counter reloads only on accept.

Reset
REQ-033 When rst_i=0 at a clock edge, the block SHALL enter IDLE, clear the counter and holding registers, and drive resp_valid_o=0, resp_err_o=0, resp_rdata_o=0.
REQ-034 After reset, req_ready_o SHALL be 1, and stall_o SHALL follow REQ-029.
REQ-035 Reset mid-transaction SHALL abort it: no response and no storage write, including a reset asserted in the RESP cycle.
REQ-036 Storage contents SHALL NOT be cleared by reset.

Structure
REQ-037 Shared package dmem_pkg SHALL hold the state enum (IDLE/BUSY/RESP), the DEPTH_WORDS and LATENCY defaults, and the counter width constant.
REQ-038 Storage SHALL be the sub-module dmem_array: synchronous write and combinational read, 32-bit x DEPTH_WORDS.
REQ-039 The FSM, counter, legality check and output logic SHALL reside in dmem_responder.

Verification
REQ-040 Store then load, LATENCY=3:
- store 0xDEADBEEF at addr 0x10 -> resp_valid_o at accept+3 with err=0;
- then load 0x10 -> resp_rdata_o=0xDEADBEEF at accept+3.
REQ-041 Handshake timing: hold req_valid_i for a load at 0x0 ->
- stall_o=1 for cycles accept..accept+2 and 0 at accept+3;
- req_ready_o=0 during BUSY/RESP;
- next accept no earlier than accept+4.
REQ-042 Illegal access:
- load addr 0x12 -> resp_err_o=1, rdata=0;
- store addr 0x400 (DEPTH 256) -> err=1, and a later load of 0x0 still returns its prior value.
REQ-043 LATENCY=1: load 0x4 -> resp_valid_o on the cycle after accept; back-to-back requests accepted every 2 cycles.
REQ-044 Reset mid-operation: accept store 0x55 to 0x8, then assert rst_i=0 in the RESP cycle ->
- no resp_valid_o;
- load 0x8 afterwards returns the old value;
- req_ready_o=1 on the first cycle after reset.
